fp_div_ctrl: RTL and testbench
==============================

Name: fp_div_ctrl

Overview:
Sequencing controller for the iterative radix-2 mantissa divider in the floating-point unit. It accepts an FP32 operand pair over a valid/ready handshake and resolves special operands directly. For normal operands it unpacks the values, runs the divider core one quotient bit per cycle, then normalizes, rounds to nearest-even and packs the result. The result is held on an output valid/ready handshake until consumed.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa field width (hidden bit added internally)
QB, MAN_W+3, quotient bits produced by the core (mantissa + guard + extra normalization bit)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  controller idle, can accept
a  in  EXP_W+MAN_W+1  dividend, IEEE-754 format
b  in  EXP_W+MAN_W+1  divisor, IEEE-754 format
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
result  out  EXP_W+MAN_W+1  quotient a/b
flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}, valid with out_valid

Behaviour:
- Reset (async, any state, including mid-division): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, iteration counter=0, divider core cleared. An in-flight operation is discarded.
- Accept occurs on a clock edge where in_valid && in_ready. in_ready = (state==IDLE). The a/b values are captured at accept; later changes on the inputs are ignored.
- Denormals are flushed to zero on input (exp==0 means zero). Subnormal results flush to signed zero.
- Result sign = sa^sb for all non-NaN results.
- Special cases are decided at accept. The controller goes IDLE->DONE, and out_valid rises in the cycle after the accepting edge:
  - NaN operand, 0/0, or inf/inf: result 0x7FC00000, invalid=1.
  - finite/0: result ±inf, div_by_zero=1.
  - inf/finite: result ±inf.
  - 0/nonzero or finite/inf: result ±0.
- Normal path, states IDLE -> DIV -> NORM -> DONE:
  - DIV: ma={1,mant_a}, mb={1,mant_b}. The core runs restoring division of ma·2^(QB-1) by mb, producing 1 quotient bit per cycle for exactly QB cycles (26 by default). The counter counts 0..QB-1.
  - NORM (1 cycle):
    - If q[QB-1]=1: mantissa=q[QB-1:2], guard=q[1], sticky=q[0]|(rem!=0), exp=ea-eb+127.
    - Else: mantissa=q[QB-2:1], guard=q[0], sticky=(rem!=0), exp=ea-eb+126.
    - Round up when guard&&(sticky||lsb). If the mantissa carries out, exp+1 and mantissa=1.0.
    - Exponent is computed signed in EXP_W+2 bits.
    - exp>=255: ±inf, overflow=1, inexact=1.
    - exp<=0: ±0, underflow=1, inexact=1.
    - Otherwise: inexact = guard|sticky.
  - DONE: result and flags registered. out_valid=1 and held stable until out_ready; on the accepting edge go DONE->IDLE, out_valid=0.
- Latency, normal path: out_valid is high in the cycle after the 28th edge following accept (1 accept + QB div + 1 norm). Throughput is 1 operation per QB+3 cycles minimum.
- out_ready high while not in DONE has no effect. in_valid is ignored outside IDLE. There is no back-to-back accept in the same cycle a result is consumed: IDLE is re-entered first.

Decomposition:
- Shared package fp_pkg:
  - constants EXP_W, MAN_W, BIAS=127, QNAN=32'h7FC00000, INF_EXP
  - state enum {IDLE, DIV, NORM, DONE}
  - packed struct fp_flags_t {invalid, div_by_zero, overflow, underflow, inexact}
  - unpack helper function (sign/exp/mant, is_zero/is_inf/is_nan)
- Sub-module radix2_div_core (param N):
  - ports: clk, rstn, start, dividend, divisor, busy, done, quotient, remainder
  - one restoring step per cycle
  - fp_div_ctrl owns the handshake, special cases, normalization and rounding.

Test Plan:
- 0x40C00000 / 0x40000000 (6.0/2.0) -> result 0x40400000, flags 0, out_valid 28 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, inexact=1; 0x3F800000 / 0x3F800000 -> 0x3F800000, flags 0.
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1. 0/0 -> 0x7FC00000, invalid=1. Both have out_valid 1 cycle after accept.
- 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow=1. 0x00800000 / 0x40800000 -> 0x00000000, underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Result and flags stay stable and in_ready stays 0. Pulse out_ready: out_valid drops next cycle and in_ready=1.
- Deassert rstn mid-DIV (cycle 10). Outputs clear immediately. After release, a fresh 6.0/2.0 returns 0x40400000 with normal latency.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared FP32 field widths, controller state encoding, IEEE
//               exception flag layout and an operand unpack helper.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int FP_W  = EXP_W + MAN_W + 1;
  localparam int BIAS  = 127;

  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [EXP_W-1:0] INF_EXP = {EXP_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic invalid;
    logic div_by_zero;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] mant;
    logic             is_zero;
    logic             is_inf;
    logic             is_nan;
  } fp_unpacked_t;

  // Split an operand into fields and classify it. A zero exponent is treated
  // as zero regardless of the mantissa, so denormal inputs flush to zero.
  function automatic fp_unpacked_t fp_unpack(input logic [FP_W-1:0] v);
    fp_unpacked_t u;
    u.sign    = v[FP_W-1];
    u.exp     = v[FP_W-2:MAN_W];
    u.mant    = v[MAN_W-1:0];
    u.is_zero = (u.exp == '0);
    u.is_inf  = (u.exp == INF_EXP) && (u.mant == '0);
    u.is_nan  = (u.exp == INF_EXP) && (u.mant != '0);
    return u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_div_ctrl_core.sv
`default_nettype none
// ============================================================================
// Module      : radix2_div_core
// Description : Restoring radix-2 divider, one quotient bit per cycle.
//               Produces floor(dividend * 2^(N-1) / divisor) in N cycles,
//               assuming divisor <= dividend < 2*divisor on entry (true for
//               two normalized mantissas). The remainder is the true
//               remainder of that division.
// Revision    : 1.0 - initial release
// ============================================================================
module radix2_div_core #(
  parameter int N = 26,
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [W:0]   remainder
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [W:0]    rem;
  logic [W-1:0]  dsr;
  logic [N-1:0]  quo;
  logic [CW-1:0] cnt;
  logic          running;

  logic [W:0]    diff;
  logic          ge;
  logic [W-1:0]  rem_sub;
  logic          last;

  // Trial subtraction for the current step; partial remainder stays < 2*divisor.
  always_comb begin
    diff    = rem - {1'b0, dsr};
    ge      = (rem >= {1'b0, dsr});
    rem_sub = ge ? diff[W-1:0] : rem[W-1:0];
    last    = running && (cnt == CW'(N - 1));
  end

  // Step register: shift in one quotient bit per cycle while running.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem     <= '0;
      dsr     <= '0;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= {1'b0, dividend};
      dsr     <= divisor;
      quo     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      quo <= {quo[N-2:0], ge};
      if (last) begin
        // Keep the final remainder unshifted so it is the true remainder.
        rem     <= {1'b0, rem_sub};
        cnt     <= '0;
        running <= 1'b0;
      end else begin
        rem <= {rem_sub, 1'b0};
        cnt <= cnt + CW'(1);
      end
    end
  end

  // done marks the cycle in which the final step is being taken, so results
  // are complete immediately after that edge.
  assign busy      = running;
  assign done      = last;
  assign quotient  = quo;
  assign remainder = rem;

endmodule
`default_nettype wire

// File: rtl/fp_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_ctrl
// Description : FP32 divide sequencing controller. Resolves special operands
//               at accept, otherwise runs the radix-2 core, normalizes,
//               rounds to nearest-even and packs the result behind an output
//               valid/ready handshake. Field widths follow fp_pkg.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_div_ctrl #(
  parameter int EXP_W = fp_pkg::EXP_W,
  parameter int MAN_W = fp_pkg::MAN_W,
  parameter int QB    = MAN_W + 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [4:0]             flags
);

  import fp_pkg::*;

  localparam int FP_W = EXP_W + MAN_W + 1;
  localparam int MW   = MAN_W + 1;      // mantissa including hidden bit
  localparam int XW   = EXP_W + 2;      // signed working exponent width

  localparam logic [FP_W-1:0] QNAN_V = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t state, state_nx;

  fp_unpacked_t ua, ub;
  logic         accept;
  logic         sign_ab;

  logic            spec_hit;
  logic [FP_W-1:0] spec_res;
  fp_flags_t       spec_flags;

  logic             sign_q;
  logic [EXP_W-1:0] exp_a_q;
  logic [EXP_W-1:0] exp_b_q;
  logic [FP_W-1:0]  result_q;
  fp_flags_t        flags_q;

  logic          core_start;
  logic          core_busy;
  logic          core_done;
  logic [QB-1:0] core_q;
  logic [MW:0]   core_rem;

  logic [FP_W-1:0] norm_res;
  fp_flags_t       norm_flags;

  assign ua      = fp_unpack(a);
  assign ub      = fp_unpack(b);
  assign sign_ab = ua.sign ^ ub.sign;
  assign accept  = in_valid && in_ready;

  // Special-operand resolution, evaluated on the live inputs at accept.
  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
      spec_res           = QNAN_V;
      spec_flags.invalid = 1'b1;
    end else if (ub.is_zero) begin
      spec_res               = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flags.div_by_zero = 1'b1;
    end else if (ua.is_inf) begin
      spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ua.is_zero || ub.is_inf) begin
      spec_res = {sign_ab, {(FP_W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  assign core_start = accept && !spec_hit;

  radix2_div_core #(
    .N (QB),
    .W (MW)
  ) u_core (
    .clk       (clk),
    .rstn      (rstn),
    .start     (core_start),
    .dividend  ({1'b1, ua.mant}),
    .divisor   ({1'b1, ub.mant}),
    .busy      (core_busy),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = (state == IDLE) && !core_busy;
    out_valid = (state == DONE);
    case (state)
      IDLE: if (accept) state_nx = spec_hit ? DONE : DIV;
      DIV:  if (core_done) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Normalize, round to nearest-even and pack from the finished quotient.
  always_comb begin
    logic [MW-1:0]        mant_n;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [MW:0]          mant_inc;
    logic [MW-1:0]        mant_r;
    logic signed [XW-1:0] exp_base;
    logic signed [XW-1:0] exp_n;
    logic signed [XW-1:0] exp_r;

    norm_res   = '0;
    norm_flags = '0;
    exp_base   = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q}) + $signed(XW'(BIAS));

    if (core_q[QB-1]) begin
      mant_n = core_q[QB-1:2];
      guard  = core_q[1];
      sticky = core_q[0] | (|core_rem);
      exp_n  = exp_base;
    end else begin
      mant_n = core_q[QB-2:1];
      guard  = core_q[0];
      sticky = |core_rem;
      exp_n  = exp_base - $signed(XW'(1));
    end

    round_up = guard && (sticky || mant_n[0]);
    mant_inc = {1'b0, mant_n} + (MW+1)'(round_up);

    if (mant_inc[MW]) begin
      mant_r = {1'b1, {MAN_W{1'b0}}};
      exp_r  = exp_n + $signed(XW'(1));
    end else begin
      mant_r = mant_inc[MW-1:0];
      exp_r  = exp_n;
    end

    if (!exp_r[XW-1] && (exp_r[XW-2:0] >= {1'b0, INF_EXP})) begin
      norm_res            = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags.overflow = 1'b1;
      norm_flags.inexact  = 1'b1;
    end else if (exp_r[XW-1] || (exp_r == '0)) begin
      norm_res             = {sign_q, {(FP_W-1){1'b0}}};
      norm_flags.underflow = 1'b1;
      norm_flags.inexact   = 1'b1;
    end else begin
      norm_res           = {sign_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
      norm_flags.inexact = guard | sticky;
    end
  end

  // Operand capture at accept and result/flag registers held through DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign_q   <= 1'b0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else if (accept) begin
      sign_q  <= sign_ab;
      exp_a_q <= ua.exp;
      exp_b_q <= ub.exp;
      if (spec_hit) begin
        result_q <= spec_res;
        flags_q  <= spec_flags;
      end
    end else if (state == NORM) begin
      result_q <= norm_res;
      flags_q  <= norm_flags;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_div_ctrl
// Description : Scoreboard bench for fp_div_ctrl with directed FP32 vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_ctrl;

  import fp_pkg::*;

  localparam int PERIOD = 10;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  flags;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
    time         t_acc;
  } exp_t;

  exp_t sb[$];

  fp_div_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #(PERIOD/2) clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: pop on the first cycle of each out_valid, check hold stability,
  // and check in_ready once the result has been consumed.
  initial begin
    exp_t cur;
    bit   seen;
    int   lat;
    seen = 1'b0;
    cur  = '{default: '0};
    forever begin
      @(negedge clk);
      if (!rstn) begin
        seen = 1'b0;
      end else if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid actual=0x%08h required=none", result);
        end else begin
          cur = sb.pop_front();
          lat = int'(($time - cur.t_acc - PERIOD/2) / PERIOD) + 1;
          chk($sformatf("result %08h/%08h", cur.a, cur.b), result, cur.res);
          chk($sformatf("flags %08h/%08h", cur.a, cur.b), {27'd0, flags}, {27'd0, cur.fl});
          chk($sformatf("latency %08h/%08h", cur.a, cur.b), lat, cur.lat);
        end
      end else if (out_valid && seen) begin
        chk("hold_result", result, cur.res);
        chk("hold_flags", {27'd0, flags}, {27'd0, cur.fl});
        chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end else if (!out_valid && seen) begin
        seen = 1'b0;
        chk("in_ready_after_consume", {31'd0, in_ready}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] er, input logic [4:0] ef,
                       input int el, input bit expect_it);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    if (expect_it) sb.push_back('{va, vb, er, ef, el, $time});
    #1;
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while ((sb.size() != 0 || out_valid) && g < 200) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("completion_timeout", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  // flags = {invalid, div_by_zero, overflow, underflow, inexact}
  vec_t vecs[] = '{
    '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28},  // 6/2
    '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28},  // 1/3
    '{32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28},  // 1/1
    '{32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 28},  // -6/2
    '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 1},   // 1/0
    '{32'h00000000, 32'h00000000, QNAN,         5'b10000, 1},   // 0/0
    '{32'h7F800001, 32'h3F800000, QNAN,         5'b10000, 1},   // NaN/1
    '{32'h7F800000, 32'hFF800000, QNAN,         5'b10000, 1},   // inf/-inf
    '{32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, 1},   // inf/2
    '{32'h00000000, 32'h40000000, 32'h00000000, 5'b00000, 1},   // 0/2
    '{32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000, 1},   // 1/-inf
    '{32'h00000001, 32'h3F800000, 32'h00000000, 5'b00000, 1},   // denormal/1
    '{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 28},  // overflow
    '{32'h00800000, 32'h40800000, 32'h00000000, 5'b00011, 28}   // underflow
  };

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {27'd0, flags}, 32'd0);
    rstn = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl, vecs[i].lat, 1'b1);
      wait_done();
    end

    // Backpressure: result held for 10 cycles, then consumed.
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 1'b1);
    for (int g = 0; g < 200 && !out_valid; g++) @(negedge clk);
    chk("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
    repeat (10) @(negedge clk);
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    wait_done();

    // Reset during the divide, then a fresh operation.
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 1'b0);
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("midreset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_flags", {27'd0, flags}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    issue(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 1'b1);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(PERIOD * 20000);
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
